pc_gen_ras: RTL and testbench

PC_GEN_RAS -- requirements
Module: pc_gen_ras

---
 rtl/pc_gen_ras_pkg.sv | 34 +++
 rtl/pc_gen_ras_ras.sv | 66 ++++++
 rtl/pc_gen_ras.sv | 224 ++++++++++++++++++++++
 tb/tb_pc_gen_ras.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_ras_pkg.sv
// -----------------------------------------------------------------------------
// pc_gen_ras_pkg
// Shared branch header for the fetch-side PC generator. It holds the
// control-flow type encoding that ID reports on upd_type, the default global
// history length, the default reset fetch address, and the 2-bit saturating
// counter update used by the PHT.
// -----------------------------------------------------------------------------
package pc_gen_ras_pkg;

   localparam int          DEFAULT_ADDR_WIDTH = 32;
   localparam int          DEFAULT_GHR_WIDTH  = 10;
   localparam logic [31:0] DEFAULT_INIT_PC    = 32'hBFC0_0000;

   // Control-flow kind, as reported by ID and as stored in each BTB entry.
   typedef enum logic [1:0] {
      BR_BRANCH = 2'b00,
      BR_JUMP   = 2'b01,
      BR_CALL   = 2'b10,
      BR_RETURN = 2'b11
   } br_type_t;

   // Every PHT counter starts weakly not-taken.
   localparam logic [1:0] PHT_INIT = 2'b01;

   // Two-bit saturating counter step: +1 on taken, -1 on not taken, 0..3.
   function automatic logic [1:0] sat_counter(input logic [1:0] ctr,
                                              input logic       taken);
      if (taken) begin
         return (ctr == 2'b11) ? ctr : ctr + 2'b01;
      end
      return (ctr == 2'b00) ? ctr : ctr - 2'b01;
   endfunction

endpackage

// File: rtl/pc_gen_ras_ras.sv
// -----------------------------------------------------------------------------
// ras
// Circular return-address stack. A push when full overwrites the oldest
// entry and the occupancy count stays at DEPTH; a pop when empty does
// nothing. push has priority if both are raised in the same cycle.
//
// Ports
//   clk        clock
//   rst        synchronous, active-low reset (clears the occupancy count)
//   push       write push_addr as the new top
//   pop        discard the current top
//   push_addr  return address to push
//   top        current top of stack (meaningful only when !empty)
//   empty      no return address held
// -----------------------------------------------------------------------------
module ras #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_addr,
   output logic [WIDTH-1:0] top,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] stack [DEPTH];
   logic [PTR_W-1:0] sp;       // next slot to write; wraps because DEPTH is 2^n
   logic [PTR_W-1:0] top_ptr;
   logic [CNT_W-1:0] count;

   assign top_ptr = sp - PTR_W'(1);
   assign top     = stack[top_ptr];
   assign empty   = (count == '0);

   // NOTE: registers are written with <= so every flop samples the values
   // from before the edge; blocking = here would create ordering races.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sp    <= '0;
         count <= '0;
      end else if (push) begin
         sp <= sp + PTR_W'(1);
         if (count != CNT_W'(DEPTH)) begin
            count <= count + CNT_W'(1);
         end
      end else if (pop && !empty) begin
         sp    <= top_ptr;
         count <= count - CNT_W'(1);
      end
   end

   // NOTE: storage arrays carry no reset; the count alone says which
   // entries are live, so clearing the data would only cost reset fan-out.
   always_ff @(posedge clk) begin
      if (rst && push) begin
         stack[sp] <= push_addr;
      end
   end

endmodule

// File: rtl/pc_gen_ras.sv
// -----------------------------------------------------------------------------
// pc_gen_ras
// Fetch PC generator with a gshare direction predictor, a direct-mapped BTB
// and a circular return-address stack. The next fetch address is chosen by
// priority: exception redirect, ID misprediction redirect, predicted next PC
// on accept, otherwise hold. Tables are trained by ID through the upd_*
// port and are written at the clock edge, so a lookup in the same cycle
// still sees the old contents.
//
// Ports
//   clk, rst       clock; synchronous active-low reset
//   pc_ready       fetch accepts pc_out this cycle
//   exc_redirect   exception/eret redirect to exc_pc (highest priority)
//   upd_valid      resolved control-flow instruction from ID
//   upd_type       br_type_t encoding of that instruction
//   upd_taken      resolved direction
//   upd_miss       misprediction: redirect to upd_target
//   upd_pht_index  PHT index that was used when it was predicted
//   upd_pc         its address; upd_target its correct next address
//   pc_valid       pc_out is valid
//   pc_out         current fetch address
//   pred_taken     prediction for pc_out is not the sequential address
//   pht_index_out  gshare index for pc_out, to travel with the instruction
// -----------------------------------------------------------------------------
module pc_gen_ras
   import pc_gen_ras_pkg::*;
#(
   parameter int                    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int                    GHR_WIDTH  = DEFAULT_GHR_WIDTH,
   parameter int                    BTB_DEPTH  = 64,
   parameter int                    RAS_DEPTH  = 8,
   parameter logic [ADDR_WIDTH-1:0] INIT_PC    = ADDR_WIDTH'(DEFAULT_INIT_PC)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pc_ready,
   input  logic                  exc_redirect,
   input  logic [ADDR_WIDTH-1:0] exc_pc,
   input  logic                  upd_valid,
   input  logic [1:0]            upd_type,
   input  logic                  upd_taken,
   input  logic                  upd_miss,
   input  logic [GHR_WIDTH-1:0]  upd_pht_index,
   input  logic [ADDR_WIDTH-1:0] upd_pc,
   input  logic [ADDR_WIDTH-1:0] upd_target,
   output logic                  pc_valid,
   output logic [ADDR_WIDTH-1:0] pc_out,
   output logic                  pred_taken,
   output logic [GHR_WIDTH-1:0]  pht_index_out
);

   localparam int BTB_IDX_W = $clog2(BTB_DEPTH);
   localparam int TAG_W     = ADDR_WIDTH - BTB_IDX_W - 2;
   localparam int PHT_DEPTH = 1 << GHR_WIDTH;

   typedef struct packed {
      logic [TAG_W-1:0]      tag;
      br_type_t              kind;
      logic [ADDR_WIDTH-1:0] target;
   } btb_entry_t;

   // Predictor state
   logic [GHR_WIDTH-1:0] ghr;
   logic [1:0]           pht [PHT_DEPTH];
   logic [BTB_DEPTH-1:0] btb_valid;
   btb_entry_t           btb [BTB_DEPTH];

   // Lookup for the current fetch address
   logic [BTB_IDX_W-1:0]  lk_idx;
   logic [TAG_W-1:0]      lk_tag;
   btb_entry_t            lk_entry;
   logic                  lk_hit;
   logic [1:0]            pht_ctr;
   logic [ADDR_WIDTH-1:0] pc_plus4;
   logic [ADDR_WIDTH-1:0] pred_pc;
   logic                  pred_push;
   logic                  pred_pop;

   // Return-address stack interface
   logic [ADDR_WIDTH-1:0] ras_top;
   logic                  ras_empty;
   logic                  ras_push;
   logic                  ras_pop;

   // Control
   logic                  accept;
   logic                  redirect;
   logic [ADDR_WIDTH-1:0] next_pc;

   // Update side
   br_type_t             upd_kind;
   logic                 upd_is_branch;
   logic                 btb_wr;
   logic [BTB_IDX_W-1:0] wr_idx;
   logic                 unused_upd_pc_lsb;

   // ---------------------------------------------------------------- lookup
   assign pht_index_out = pc_out[GHR_WIDTH+1:2] ^ ghr;
   assign pht_ctr       = pht[pht_index_out];

   assign lk_idx   = pc_out[BTB_IDX_W+1:2];
   assign lk_tag   = pc_out[ADDR_WIDTH-1:BTB_IDX_W+2];
   assign lk_entry = btb[lk_idx];
   assign lk_hit   = btb_valid[lk_idx] && (lk_entry.tag == lk_tag);
   assign pc_plus4 = pc_out + ADDR_WIDTH'(4);

   // NOTE: every signal driven here gets a default first, so no path through
   // the case leaves one unassigned and no latch is inferred.
   always_comb begin
      pred_pc   = pc_plus4;
      pred_push = 1'b0;
      pred_pop  = 1'b0;
      if (lk_hit) begin
         unique case (lk_entry.kind)
            BR_RETURN: begin
               // An empty stack falls back to the last target seen in the BTB.
               if (!ras_empty) begin
                  pred_pc  = ras_top;
                  pred_pop = 1'b1;
               end else begin
                  pred_pc = lk_entry.target;
               end
            end
            BR_CALL: begin
               pred_pc   = lk_entry.target;
               pred_push = 1'b1;
            end
            BR_JUMP: begin
               pred_pc = lk_entry.target;
            end
            BR_BRANCH: begin
               if (pht_ctr[1]) begin
                  pred_pc = lk_entry.target;
               end
            end
         endcase
      end
   end

   assign pred_taken = (pred_pc != pc_plus4);

   // ------------------------------------------------------------ next PC
   assign accept   = pc_valid && pc_ready;
   assign redirect = exc_redirect || (upd_valid && upd_miss);

   always_comb begin
      if (exc_redirect) begin
         next_pc = exc_pc;
      end else if (upd_valid && upd_miss) begin
         next_pc = upd_target;
      end else if (accept) begin
         next_pc = pred_pc;
      end else begin
         next_pc = pc_out;
      end
   end

   // pc_valid stays low on the first edge after reset, so INIT_PC is
   // presented for at least one valid cycle before fetch can advance it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_out   <= INIT_PC;
         pc_valid <= 1'b0;
      end else begin
         pc_out   <= next_pc;
         pc_valid <= 1'b1;
      end
   end

   // ------------------------------------------------------------ RAS
   // Speculative only: a redirect in the same cycle discards the fetch, and
   // the stack is never repaired after a miss or exception.
   assign ras_push = accept && !redirect && pred_push;
   assign ras_pop  = accept && !redirect && pred_pop;

   ras #(
      .DEPTH (RAS_DEPTH),
      .WIDTH (ADDR_WIDTH)
   ) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_addr (pc_plus4),
      .top       (ras_top),
      .empty     (ras_empty)
   );

   // ------------------------------------------------------------ training
   assign upd_kind          = br_type_t'(upd_type);
   assign upd_is_branch     = upd_valid && (upd_kind == BR_BRANCH);
   assign btb_wr            = upd_valid && upd_taken;
   assign wr_idx            = upd_pc[BTB_IDX_W+1:2];
   assign unused_upd_pc_lsb = ^upd_pc[1:0];

   always_ff @(posedge clk) begin
      if (!rst) begin
         ghr <= '0;
         for (int i = 0; i < PHT_DEPTH; i++) begin
            pht[i] <= PHT_INIT;
         end
      end else if (upd_is_branch) begin
         ghr                <= {ghr[GHR_WIDTH-2:0], upd_taken};
         pht[upd_pht_index] <= sat_counter(pht[upd_pht_index], upd_taken);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         btb_valid <= '0;
      end else if (btb_wr) begin
         btb_valid[wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst && btb_wr) begin
         btb[wr_idx] <= '{tag:    upd_pc[ADDR_WIDTH-1:BTB_IDX_W+2],
                          kind:   upd_kind,
                          target: upd_target};
      end
   end

endmodule

// File: tb/tb_pc_gen_ras.sv
// -----------------------------------------------------------------------------
// tb_pc_gen_ras
// Directed bench for pc_gen_ras at default parameters (32-bit PC, 10-bit
// GHR, 64-entry BTB, 8-entry RAS). Inputs change 1 ns after a rising edge
// and outputs are read at the same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_pc_gen_ras;
   import pc_gen_ras_pkg::*;

   localparam int AW = 32;
   localparam int GW = 10;

   localparam logic [AW-1:0] B_PC   = 32'h8000_0A00;   // branch under test
   localparam logic [AW-1:0] B_TGT  = 32'h8000_0B00;
   localparam logic [AW-1:0] C_BASE = 32'h8000_0404;   // first call of the chain
   localparam logic [AW-1:0] R_FALL = 32'h9000_0000;   // BTB target of returns

   logic          clk = 1'b0;
   logic          rst;
   logic          pc_ready;
   logic          exc_redirect;
   logic [AW-1:0] exc_pc;
   logic          upd_valid;
   logic [1:0]    upd_type;
   logic          upd_taken;
   logic          upd_miss;
   logic [GW-1:0] upd_pht_index;
   logic [AW-1:0] upd_pc;
   logic [AW-1:0] upd_target;
   logic          pc_valid;
   logic [AW-1:0] pc_out;
   logic          pred_taken;
   logic [GW-1:0] pht_index_out;

   int n_vec = 0;
   int n_err = 0;

   logic [AW-1:0] exp_q[$];

   pc_gen_ras dut (
      .clk           (clk),
      .rst           (rst),
      .pc_ready      (pc_ready),
      .exc_redirect  (exc_redirect),
      .exc_pc        (exc_pc),
      .upd_valid     (upd_valid),
      .upd_type      (upd_type),
      .upd_taken     (upd_taken),
      .upd_miss      (upd_miss),
      .upd_pht_index (upd_pht_index),
      .upd_pc        (upd_pc),
      .upd_target    (upd_target),
      .pc_valid      (pc_valid),
      .pc_out        (pc_out),
      .pred_taken    (pred_taken),
      .pht_index_out (pht_index_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      exc_redirect  = 1'b0;
      exc_pc        = '0;
      upd_valid     = 1'b0;
      upd_type      = BR_BRANCH;
      upd_taken     = 1'b0;
      upd_miss      = 1'b0;
      upd_pht_index = '0;
      upd_pc        = '0;
      upd_target    = '0;
   endtask

   // One cycle of ID feedback, then the update port goes quiet again.
   task automatic update(input logic [1:0] kind, input logic taken,
                         input logic miss, input logic [GW-1:0] idx,
                         input logic [AW-1:0] pc, input logic [AW-1:0] tgt);
      upd_valid     = 1'b1;
      upd_type      = kind;
      upd_taken     = taken;
      upd_miss      = miss;
      upd_pht_index = idx;
      upd_pc        = pc;
      upd_target    = tgt;
      tick();
      upd_valid = 1'b0;
      upd_miss  = 1'b0;
   endtask

   // Not-taken jump with miss: redirects without touching GHR, PHT or BTB.
   task automatic redirect_to(input logic [AW-1:0] a);
      update(BR_JUMP, 1'b0, 1'b1, '0, '0, a);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst      = 1'b0;
      pc_ready = 1'b0;
      clear_inputs();

      // ---- reset state
      tick();
      tick();
      check("rst_valid", pc_valid, 0);
      check("rst_pc", pc_out, 32'hBFC0_0000);
      check("rst_pht_idx", pht_index_out, 0);

      // ---- sequential fetch after reset
      rst      = 1'b1;
      pc_ready = 1'b1;
      tick();
      check("seq0_valid", pc_valid, 1);
      check("seq0_pc", pc_out, 32'hBFC0_0000);
      check("seq0_pred", pred_taken, 0);
      tick();
      check("seq1_pc", pc_out, 32'hBFC0_0004);
      check("seq1_pred", pred_taken, 0);
      tick();
      check("seq2_pc", pc_out, 32'hBFC0_0008);
      check("seq2_pred", pred_taken, 0);

      // ---- jump learned in the BTB while fetch is stalled
      pc_ready = 1'b0;
      update(BR_JUMP, 1'b1, 1'b0, '0, 32'hBFC0_0010, 32'hBFC0_0100);
      check("stall_hold", pc_out, 32'hBFC0_0008);
      pc_ready = 1'b1;
      tick();
      check("jmp_pc0", pc_out, 32'hBFC0_000C);
      tick();
      check("jmp_pc1", pc_out, 32'hBFC0_0010);
      check("jmp_pred", pred_taken, 1);
      tick();
      check("jmp_tgt", pc_out, 32'hBFC0_0100);
      check("jmp_tgt_pred", pred_taken, 0);

      // ---- exception beats miss, both applied during a stall
      pc_ready      = 1'b0;
      exc_redirect  = 1'b1;
      exc_pc        = 32'hBFC0_0380;
      upd_valid     = 1'b1;
      upd_type      = BR_BRANCH;
      upd_taken     = 1'b0;
      upd_miss      = 1'b1;
      upd_pht_index = '0;
      upd_pc        = '0;
      upd_target    = 32'h1234_5678;
      tick();
      clear_inputs();
      check("exc_prio", pc_out, 32'hBFC0_0380);
      tick();
      check("exc_hold", pc_out, 32'hBFC0_0380);
      redirect_to(32'h8000_0100);
      check("miss_redirect", pc_out, 32'h8000_0100);

      // ---- call then return
      update(BR_CALL,   1'b1, 1'b0, '0, 32'h8000_0000, 32'h8000_1040);
      update(BR_RETURN, 1'b1, 1'b0, '0, 32'h8000_1040, 32'h8000_2000);
      redirect_to(32'h8000_0000);
      check("call_pc", pc_out, 32'h8000_0000);
      check("call_pred", pred_taken, 1);
      pc_ready = 1'b1;
      tick();
      check("callee_pc", pc_out, 32'h8000_1040);
      check("ret_pred", pred_taken, 1);
      tick();
      check("ret_pc", pc_out, 32'h8000_0004);
      check("ret_after_pred", pred_taken, 0);

      // ---- RAS overflow: 9 chained calls, then 9 returns
      // Call i sits at C_BASE+8i and calls i+1; a return sits right after
      // each call. The last call targets its own return slot.
      pc_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         logic [AW-1:0] c;
         c = C_BASE + AW'(8 * i);
         update(BR_CALL, 1'b1, 1'b0, '0, c, (i < 8) ? c + 32'd8 : c + 32'd4);
         update(BR_RETURN, 1'b1, 1'b0, '0, c + 32'd4, R_FALL);
      end
      redirect_to(C_BASE);
      check("chain_start", pc_out, C_BASE);
      for (int i = 1; i <= 8; i++) exp_q.push_back(C_BASE + AW'(8 * i));
      exp_q.push_back(C_BASE + 32'd68);               // return after call 8
      for (int i = 8; i >= 1; i--) exp_q.push_back(C_BASE + AW'(8 * i + 4));
      exp_q.push_back(R_FALL);                        // oldest address was lost
      pc_ready = 1'b1;
      foreach (exp_q[k]) begin
         tick();
         check($sformatf("ras_seq%0d", k), pc_out, exp_q[k]);
      end
      check("ras_final_pred", pred_taken, 0);

      // ---- gshare: two taken updates make the branch predicted taken
      // GHR is 0 here; it becomes 2'b11, so the lookup index is 0x280^3.
      pc_ready = 1'b0;
      update(BR_BRANCH, 1'b1, 1'b0, 10'h283, B_PC, B_TGT);
      update(BR_BRANCH, 1'b1, 1'b0, 10'h283, B_PC, B_TGT);
      redirect_to(B_PC);
      check("br_t_idx", pht_index_out, 10'h283);
      check("br_t_pred", pred_taken, 1);
      pc_ready = 1'b1;
      tick();
      check("br_t_pc", pc_out, B_TGT);

      // ---- three not-taken updates: GHR becomes 0x18, index 0x298
      pc_ready = 1'b0;
      for (int i = 0; i < 3; i++) update(BR_BRANCH, 1'b0, 1'b0, 10'h298, B_PC, B_TGT);
      redirect_to(B_PC);
      check("br_nt_idx", pht_index_out, 10'h298);
      check("br_nt_pred", pred_taken, 0);
      pc_ready = 1'b1;
      tick();
      check("br_nt_pc", pc_out, B_PC + 32'd4);

      // ---- reset during a stall with a BTB update pending
      pc_ready      = 1'b0;
      upd_valid     = 1'b1;
      upd_type      = BR_JUMP;
      upd_taken     = 1'b1;
      upd_pc        = 32'h8000_0C00;
      upd_target    = 32'h8000_0D00;
      rst           = 1'b0;
      tick();
      clear_inputs();
      check("rst2_pc", pc_out, 32'hBFC0_0000);
      check("rst2_valid", pc_valid, 0);
      rst = 1'b1;
      tick();
      check("rst2_rel_valid", pc_valid, 1);
      check("rst2_rel_pc", pc_out, 32'hBFC0_0000);
      redirect_to(B_PC);
      check("rst2_ghr_idx", pht_index_out, 10'h280);
      check("rst2_btb_miss_b", pred_taken, 0);
      redirect_to(32'h8000_0C00);
      check("rst2_btb_miss_upd", pred_taken, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
